// File: rtl/dfr_pkg.sv
// Shared definitions for the DFR sample-indexing path: counter sizing,
// total sample count, and the sample index type used by the controller
// and the reservoir-history memory.
package dfr_pkg;

    localparam int SAMPLE_IDX_W = 32;

    typedef logic [SAMPLE_IDX_W-1:0] sample_idx_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cntr_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Warm-up samples plus recorded samples.
    function automatic int total_samples(input int num_init, input int num_test);
        return num_init + num_test;
    endfunction

endpackage

// File: rtl/dfr_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
// An enable while already at MAX_VAL holds the count and raises ovf for
// that cycle so the parent can flag the overrun.
module dfr_sat_counter
    import dfr_pkg::*;
#(
    parameter int MAX_VAL = 1,
    parameter int WIDTH   = cntr_w(MAX_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             ovf
);

    assign at_max = (cnt == WIDTH'(MAX_VAL));
    assign ovf    = en & ~clr & at_max;

    // Count register: clear first, then increment unless saturated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dfr_sample_sequencer.sv
// Sample-indexing stage for the DFR core controller: owns the warm-up,
// total-sample and history counters, decodes controller status, drives
// the input-sample address and the registered history write port.
module dfr_sample_sequencer
    import dfr_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int NUM_INIT_SAMPLES = 10,
    parameter int NUM_TEST_SAMPLES = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_cntr_rst,
    input  logic                  sample_cntr_en,
    input  logic                  init_sample_cntr_rst,
    input  logic                  init_sample_cntr_en,
    input  logic                  reservoir_history_rst,
    input  logic                  reservoir_history_en,
    output logic                  reservoir_init_busy,
    output logic                  reservoir_busy,
    output logic                  reservoir_filled,
    output logic [ADDR_WIDTH-1:0] sample_addr,
    output logic                  history_wr_en,
    output logic [ADDR_WIDTH-1:0] history_wr_addr,
    output logic                  overrun
);

    localparam int TOTAL  = total_samples(NUM_INIT_SAMPLES, NUM_TEST_SAMPLES);
    localparam int INIT_W = cntr_w(NUM_INIT_SAMPLES);
    localparam int SAMP_W = cntr_w(TOTAL);
    localparam int HIST_W = cntr_w(NUM_TEST_SAMPLES);

    logic [INIT_W-1:0] init_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [HIST_W-1:0] hist_cnt;
    logic              init_at_max, samp_at_max, hist_at_max;
    logic              init_ovf, samp_ovf, hist_ovf;
    logic              hist_write;

    dfr_sat_counter #(.MAX_VAL(NUM_INIT_SAMPLES), .WIDTH(INIT_W)) u_init_cntr (
        .clk    (clk),
        .rst    (rst),
        .clr    (init_sample_cntr_rst),
        .en     (init_sample_cntr_en),
        .cnt    (init_cnt),
        .at_max (init_at_max),
        .ovf    (init_ovf)
    );

    dfr_sat_counter #(.MAX_VAL(TOTAL), .WIDTH(SAMP_W)) u_samp_cntr (
        .clk    (clk),
        .rst    (rst),
        .clr    (sample_cntr_rst),
        .en     (sample_cntr_en),
        .cnt    (samp_cnt),
        .at_max (samp_at_max),
        .ovf    (samp_ovf)
    );

    dfr_sat_counter #(.MAX_VAL(NUM_TEST_SAMPLES), .WIDTH(HIST_W)) u_hist_cntr (
        .clk    (clk),
        .rst    (rst),
        .clr    (reservoir_history_rst),
        .en     (reservoir_history_en),
        .cnt    (hist_cnt),
        .at_max (hist_at_max),
        .ovf    (hist_ovf)
    );

    // Counters saturate at their max, so "below max" is exactly "not at max".
    assign reservoir_init_busy = ~init_at_max;
    assign reservoir_filled    = init_at_max;
    assign reservoir_busy      = ~samp_at_max;
    assign sample_addr         = ADDR_WIDTH'(samp_cnt);

    // A write happens only when the history counter actually advances.
    assign hist_write = reservoir_history_en & ~hist_at_max & ~reservoir_history_rst;

    // History write port: one-cycle strobe, address holds between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history_wr_en   <= 1'b0;
            history_wr_addr <= '0;
        end else begin
            history_wr_en <= hist_write;
            if (hist_write) begin
                history_wr_addr <= ADDR_WIDTH'(hist_cnt);
            end
        end
    end

    // Sticky overrun; a history clear in the same cycle wins over any new event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (reservoir_history_rst) begin
            overrun <= 1'b0;
        end else if (init_ovf || samp_ovf || hist_ovf) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: doc/dfr_sample_sequencer.md
# dfr_sample_sequencer

Sample-indexing stage feeding the DFR core controller. It owns the init-sample, total-sample and reservoir-history counters that the controller enables and clears. It decodes them into the controller's `reservoir_init_busy`, `reservoir_busy` and `reservoir_filled` status inputs. It also produces the input-sample read address and a registered write strobe/address for the reservoir-history memory.

## Interface
- `ADDR_WIDTH`, 32: width of `sample_addr` and `history_wr_addr`.
- `NUM_INIT_SAMPLES`, 10: warm-up samples run before history capture; legal range ≥1.
- `NUM_TEST_SAMPLES`, 100: samples whose reservoir state is recorded; legal range ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sample_cntr_rst`  in  1  synchronous clear of the total sample counter.
- `sample_cntr_en`  in  1  one-cycle pulse per completed sample.
- `init_sample_cntr_rst`  in  1  synchronous clear of the init counter.
- `init_sample_cntr_en`  in  1  one-cycle pulse per completed warm-up sample.
- `reservoir_history_rst`  in  1  synchronous clear of the history counter and the overrun flag.
- `reservoir_history_en`  in  1  request to record the current reservoir state.
- `reservoir_init_busy`  out  1  warm-up incomplete.
- `reservoir_busy`  out  1  samples remain.
- `reservoir_filled`  out  1  warm-up complete.
- `sample_addr`  out  ADDR_WIDTH  index of the next input sample, zero-extended.
- `history_wr_en`  out  1  registered one-cycle write strobe.
- `history_wr_addr`  out  ADDR_WIDTH  registered history row index.
- `overrun`  out  1  sticky error flag.

## Operation
- **Counters.** Three registered counters, each `CNTR_W = $clog2(N+1)` bits wide:
  - `init_cnt`: 0..`NUM_INIT_SAMPLES`.
  - `samp_cnt`: 0..`TOTAL`, where `TOTAL = NUM_INIT_SAMPLES + NUM_TEST_SAMPLES`.
  - `hist_cnt`: 0..`NUM_TEST_SAMPLES`.
- **Counter update rule.** Per counter, the synchronous clear has priority over its enable. An enable at max saturates: the counter holds and `overrun` is set.
- **Status decodes.** Combinational from the counter registers:
  - `reservoir_init_busy = (init_cnt < NUM_INIT_SAMPLES)`.
  - `reservoir_filled = ~reservoir_init_busy`.
  - `reservoir_busy = (samp_cnt < TOTAL)`.
- **Sample address.** `sample_addr = samp_cnt`, zero-extended.
- **History write.**
  - On `reservoir_history_en` with `hist_cnt < NUM_TEST_SAMPLES`: next edge sets `history_wr_en=1`, `history_wr_addr=hist_cnt` (pre-increment value), and `hist_cnt` increments.
  - Otherwise `history_wr_en=0`, and `history_wr_addr` holds its last value.
  - `reservoir_history_en` at `hist_cnt==NUM_TEST_SAMPLES`: no write, `overrun` set.
- **`overrun`.**
  - Sticky; cleared only by `rst` or `reservoir_history_rst`.
  - `reservoir_history_rst` concurrent with any overrun event: clear wins.
- **Simultaneous events.**
  - Clears and enables on different counters act independently in the same cycle.
  - The controller pulses `sample_cntr_en` and `init_sample_cntr_en` together during warm-up; both counters increment.

## Timing
- **Asynchronous reset** (`rst`=0): all counters 0, `history_wr_en`=0, `history_wr_addr`=0, `overrun`=0. Outputs are therefore:
  - `reservoir_init_busy`=1, `reservoir_filled`=0.
  - `reservoir_busy`=1, `sample_addr`=0.
- Reset deassertion is synchronised externally. Reset mid-run discards all progress with no partial write.
- **Status latency.** Status outputs reflect an enable pulse on the edge that registers it: zero added latency. The controller samples them in the state entered on that same edge.
- **History write latency.** `history_wr_en`/`history_wr_addr` lag `reservoir_history_en` by one cycle. Back-to-back requests give back-to-back writes at consecutive addresses.
- **Clear timing.** A clear takes effect at the next edge. Decodes during that cycle still reflect the old count.

## Structure
- **`dfr_pkg`.** Holds:
  - the `CNTR_W` helper function;
  - the `TOTAL` derivation;
  - a `sample_idx_t` typedef shared with the controller and the history memory.
- **`dfr_sat_counter` sub-module.** Parameters: max value and width. Ports: `clk`, `rst`, `clr`, `en`, `cnt`, `at_max`, `ovf` (one-cycle pulse when en at max). Instantiated three times.
- **Top-level logic.** The decodes, the history strobe register and the `overrun` OR/hold logic live in the top module.

## Test plan
All scenarios use `NUM_INIT_SAMPLES=3`, `NUM_TEST_SAMPLES=4`.
- **Reset values.** Assert `rst` low mid-count, with `samp_cnt`=5 → all outputs return immediately (asynchronously) to reset values: `reservoir_init_busy`=1, `sample_addr`=0.
- **Warm-up.** 3 joint `sample_cntr_en`+`init_sample_cntr_en` pulses → after the 3rd edge `reservoir_filled`=1, `reservoir_init_busy`=0, `sample_addr`=3.
- **History capture.** 4 pulses of `reservoir_history_en`, each with a `sample_cntr_en` → `history_wr_en` pulses with addresses 0,1,2,3, each one cycle after its request. After the last one `reservoir_busy`=0 and `sample_addr`=7.
- **Overrun.** A 5th `reservoir_history_en` → no `history_wr_en`, `overrun`=1 and stays set. Then `reservoir_history_rst` → `overrun`=0, `hist_cnt`=0.
- **Clear priority.** `sample_cntr_rst` and `sample_cntr_en` in the same cycle at `samp_cnt`=2 → `samp_cnt`=0, no overrun.
- **Saturation.** `sample_cntr_en` at `samp_cnt`=7 → count holds at 7, `overrun`=1, `reservoir_busy` stays 0.
